// File: rtl/instruction_buffer.sv
// rtl/instruction_buffer.sv - two-wide push / two-wide pop circular instruction FIFO
module instruction_buffer #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [31:0]              instructionA,
    input  logic [31:0]              addressA,
    input  logic                     instructionA_valid,
    input  logic [31:0]              instructionB,
    input  logic [31:0]              addressB,
    input  logic                     instructionB_valid,
    input  logic                     pop0,
    input  logic                     pop1,
    output logic [31:0]              entry0_instruction,
    output logic [31:0]              entry0_address,
    output logic [31:0]              entry1_instruction,
    output logic [31:0]              entry1_address,
    output logic [$clog2(DEPTH):0]   entry_count,
    output logic                     stall
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   addr_mem  [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic [1:0]    pop_req;
    logic [1:0]    n_valid;
    logic [CW-1:0] n_pop;
    logic [CW-1:0] n_push;
    logic [CW-1:0] free;
    logic [CW-1:0] count_next;
    logic [31:0]   first_instr;
    logic [31:0]   first_addr;
    logic          wr0;
    logic          wr1;
    logic [PW-1:0] tail_p1;
    logic [PW-1:0] head_p1;

    always_comb begin
        pop_req     = 2'd0;
        n_pop       = '0;
        free        = '0;
        n_valid     = 2'd0;
        n_push      = '0;
        first_instr = instructionB;
        first_addr  = addressB;
        wr0         = 1'b0;
        wr1         = 1'b0;
        count_next  = count;

        if (pop0 && pop1) begin
            pop_req = 2'd2;
        end else if (pop0) begin
            pop_req = 2'd1;
        end

        n_pop = (CW'(pop_req) > count) ? count : CW'(pop_req);
        // Same-cycle pops free their slots before the pushes land.
        free  = DEPTH_C - count + n_pop;

        n_valid = {1'b0, instructionA_valid} + {1'b0, instructionB_valid};
        if (instructionA_valid) begin
            first_instr = instructionA;
            first_addr  = addressA;
        end

        // Clipping drops the youngest push first, since B always lands second.
        n_push = (CW'(n_valid) > free) ? free : CW'(n_valid);
        wr0    = (n_push != '0);
        wr1    = (n_push == CW'(2));

        count_next = count - n_pop + n_push;
    end

    assign tail_p1 = tail + PW'(1);
    assign head_p1 = head + PW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(n_pop);
            tail  <= tail + PW'(n_push);
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !flush) begin
            if (wr0) begin
                instr_mem[tail] <= first_instr;
                addr_mem[tail]  <= first_addr;
            end
            if (wr1) begin
                instr_mem[tail_p1] <= instructionB;
                addr_mem[tail_p1]  <= addressB;
            end
        end
    end

    assign entry0_instruction = (count != '0)      ? instr_mem[head]    : 32'h0;
    assign entry0_address     = (count != '0)      ? addr_mem[head]     : 32'h0;
    assign entry1_instruction = (count >= CW'(2))  ? instr_mem[head_p1] : 32'h0;
    assign entry1_address     = (count >= CW'(2))  ? addr_mem[head_p1]  : 32'h0;

    assign entry_count = count;
    assign stall       = (count >= CW'(DEPTH - 1));

endmodule

// File: tb/tb_instruction_buffer.sv
// tb/tb_instruction_buffer.sv - directed self-checking bench for instruction_buffer
module tb_instruction_buffer;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] instructionA;
    logic [31:0] addressA;
    logic        instructionA_valid;
    logic [31:0] instructionB;
    logic [31:0] addressB;
    logic        instructionB_valid;
    logic        pop0;
    logic        pop1;
    logic [31:0] entry0_instruction;
    logic [31:0] entry0_address;
    logic [31:0] entry1_instruction;
    logic [31:0] entry1_address;
    logic [3:0]  entry_count;
    logic        stall;

    int total = 0;
    int bad   = 0;

    instruction_buffer #(.DEPTH(8)) dut (
        .clk                (clk),
        .rst                (rst),
        .flush              (flush),
        .instructionA       (instructionA),
        .addressA           (addressA),
        .instructionA_valid (instructionA_valid),
        .instructionB       (instructionB),
        .addressB           (addressB),
        .instructionB_valid (instructionB_valid),
        .pop0               (pop0),
        .pop1               (pop1),
        .entry0_instruction (entry0_instruction),
        .entry0_address     (entry0_address),
        .entry1_instruction (entry1_instruction),
        .entry1_address     (entry1_address),
        .entry_count        (entry_count),
        .stall              (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        flush = 0; instructionA_valid = 0; instructionB_valid = 0; pop0 = 0; pop1 = 0;
        instructionA = 0; addressA = 0; instructionB = 0; addressB = 0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset();
        rst = 0;
        idle();
        repeat (3) @(negedge clk);
        total++; if (entry_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", entry_count); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b exp=0", stall); end
        total++; if (entry0_instruction !== 32'h0 || entry1_address !== 32'h0) begin bad++;
            $display("FAIL reset_entries got=%h/%h exp=0/0", entry0_instruction, entry1_address); end
        rst = 1;
        @(negedge clk);
    endtask

    task automatic test_single_push();
        instructionA_valid = 1; instructionA = 32'h11111111; addressA = 32'h12345678;
        step();
        total++; if (entry_count !== 4'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", entry_count); end
        total++; if (entry0_instruction !== 32'h11111111 || entry0_address !== 32'h12345678) begin bad++;
            $display("FAIL single_entry0 got=%h/%h exp=11111111/12345678", entry0_instruction, entry0_address); end
        total++; if (entry1_instruction !== 32'h0 || entry1_address !== 32'h0) begin bad++;
            $display("FAIL single_entry1 got=%h/%h exp=0/0", entry1_instruction, entry1_address); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL single_stall got=%0b exp=0", stall); end
        step();
        total++; if (entry_count !== 4'd1) begin bad++; $display("FAIL single_hold got=%0d exp=1", entry_count); end
        pop0 = 1;
        step();
        total++; if (entry_count !== 4'd0) begin bad++; $display("FAIL single_pop got=%0d exp=0", entry_count); end
    endtask

    task automatic test_dual();
        instructionA_valid = 1; instructionA = 32'hA0; addressA = 32'h100;
        instructionB_valid = 1; instructionB = 32'hB0; addressB = 32'h104;
        step();
        total++; if (entry_count !== 4'd2) begin bad++; $display("FAIL dual_count got=%0d exp=2", entry_count); end
        total++; if (entry0_instruction !== 32'hA0 || entry0_address !== 32'h100) begin bad++;
            $display("FAIL dual_entry0 got=%h/%h exp=a0/100", entry0_instruction, entry0_address); end
        total++; if (entry1_instruction !== 32'hB0 || entry1_address !== 32'h104) begin bad++;
            $display("FAIL dual_entry1 got=%h/%h exp=b0/104", entry1_instruction, entry1_address); end
        pop0 = 1; pop1 = 1;
        step();
        total++; if (entry_count !== 4'd0) begin bad++; $display("FAIL dual_pop_count got=%0d exp=0", entry_count); end
        total++; if (entry0_instruction !== 32'h0 || entry1_instruction !== 32'h0) begin bad++;
            $display("FAIL dual_pop_entries got=%h/%h exp=0/0", entry0_instruction, entry1_instruction); end
    endtask

    task automatic test_fill_wrap();
        int nk = 0;
        int h  = 0;
        for (int p = 0; p < 3; p++) begin
            instructionA_valid = 1; instructionA = 32'hC000_0000 + nk; addressA = 32'h1000 + 4*nk;
            instructionB_valid = 1; instructionB = 32'hC000_0001 + nk; addressB = 32'h1004 + 4*nk;
            nk += 2;
            step();
        end
        total++; if (entry_count !== 4'd6 || stall !== 1'b0) begin bad++;
            $display("FAIL fill6 got=%0d/%0b exp=6/0", entry_count, stall); end
        instructionA_valid = 1; instructionA = 32'hC000_0000 + nk; addressA = 32'h1000 + 4*nk;
        nk++;
        step();
        total++; if (entry_count !== 4'd7 || stall !== 1'b1) begin bad++;
            $display("FAIL fill7 got=%0d/%0b exp=7/1", entry_count, stall); end
        pop0 = 1;
        instructionA_valid = 1; instructionA = 32'hC000_0000 + nk; addressA = 32'h1000 + 4*nk;
        instructionB_valid = 1; instructionB = 32'hC000_0001 + nk; addressB = 32'h1004 + 4*nk;
        nk += 2; h = 1;
        step();
        total++; if (entry_count !== 4'd8 || stall !== 1'b1) begin bad++;
            $display("FAIL fill8 got=%0d/%0b exp=8/1", entry_count, stall); end
        total++; if (entry0_address !== 32'h1004) begin bad++;
            $display("FAIL fill8_head got=%h exp=1004", entry0_address); end
        instructionA_valid = 1; instructionA = 32'hDEAD0000; addressA = 32'hDEAD0000;
        instructionB_valid = 1; instructionB = 32'hDEAD0001; addressB = 32'hDEAD0004;
        step();
        total++; if (entry_count !== 4'd8) begin bad++; $display("FAIL overflow_drop got=%0d exp=8", entry_count); end
        for (int c = 0; c < 10; c++) begin
            pop0 = 1; pop1 = 1;
            instructionA_valid = 1; instructionA = 32'hC000_0000 + nk; addressA = 32'h1000 + 4*nk;
            instructionB_valid = 1; instructionB = 32'hC000_0001 + nk; addressB = 32'h1004 + 4*nk;
            nk += 2; h += 2;
            step();
            total++; if (entry_count !== 4'd8 || entry0_address !== 32'h1000 + 4*h
                         || entry1_address !== 32'h1004 + 4*h
                         || entry0_instruction !== 32'hC000_0000 + h) begin bad++;
                $display("FAIL wrap_order cycle=%0d got=%0d/%h/%h exp=8/%h/%h", c, entry_count,
                         entry0_address, entry1_address, 32'h1000 + 4*h, 32'h1004 + 4*h); end
        end
        for (int c = 0; c < 4; c++) begin
            pop0 = 1; pop1 = 1;
            h += 2;
            step();
            if (c < 3) begin
                total++; if (entry0_address !== 32'h1000 + 4*h) begin bad++;
                    $display("FAIL drain_order cycle=%0d got=%h exp=%h", c, entry0_address, 32'h1000 + 4*h); end
            end
        end
        total++; if (entry_count !== 4'd0 || stall !== 1'b0) begin bad++;
            $display("FAIL drain_empty got=%0d/%0b exp=0/0", entry_count, stall); end
    endtask

    task automatic test_flush();
        for (int p = 0; p < 3; p++) begin
            instructionA_valid = 1; instructionA = 32'hF0 + p; addressA = 32'h2000 + 8*p;
            instructionB_valid = (p < 2); instructionB = 32'hF8 + p; addressB = 32'h2004 + 8*p;
            step();
        end
        total++; if (entry_count !== 4'd5) begin bad++; $display("FAIL flush_pre got=%0d exp=5", entry_count); end
        flush = 1; pop0 = 1;
        instructionA_valid = 1; instructionA = 32'h5555AAAA; addressA = 32'h3000;
        step();
        total++; if (entry_count !== 4'd0 || stall !== 1'b0) begin bad++;
            $display("FAIL flush_clear got=%0d/%0b exp=0/0", entry_count, stall); end
        total++; if (entry0_instruction !== 32'h0) begin bad++;
            $display("FAIL flush_entry0 got=%h exp=0", entry0_instruction); end
        instructionB_valid = 1; instructionB = 32'h77; addressB = 32'h4000;
        step();
        total++; if (entry_count !== 4'd1 || entry0_instruction !== 32'h77 || entry0_address !== 32'h4000) begin bad++;
            $display("FAIL b_only got=%0d/%h/%h exp=1/77/4000", entry_count, entry0_instruction, entry0_address); end
        pop0 = 1;
        step();
    endtask

    task automatic test_pop_edges();
        instructionA_valid = 1; instructionA = 32'h31; addressA = 32'h500;
        instructionB_valid = 1; instructionB = 32'h32; addressB = 32'h504;
        step();
        instructionA_valid = 1; instructionA = 32'h33; addressA = 32'h508;
        step();
        pop1 = 1;
        step();
        total++; if (entry_count !== 4'd3 || entry0_instruction !== 32'h31) begin bad++;
            $display("FAIL pop1_alone got=%0d/%h exp=3/31", entry_count, entry0_instruction); end
        pop0 = 1; pop1 = 1;
        step();
        total++; if (entry_count !== 4'd1 || entry0_instruction !== 32'h33) begin bad++;
            $display("FAIL pop_two got=%0d/%h exp=1/33", entry_count, entry0_instruction); end
        pop0 = 1; pop1 = 1;
        step();
        total++; if (entry_count !== 4'd0 || entry0_instruction !== 32'h0) begin bad++;
            $display("FAIL underflow got=%0d/%h exp=0/0", entry_count, entry0_instruction); end
        pop0 = 1; pop1 = 1;
        step();
        total++; if (entry_count !== 4'd0 || stall !== 1'b0) begin bad++;
            $display("FAIL empty_pop got=%0d/%0b exp=0/0", entry_count, stall); end
    endtask

    task automatic test_async_reset();
        for (int p = 0; p < 2; p++) begin
            instructionA_valid = 1; instructionA = 32'h60 + p; addressA = 32'h600 + p;
            instructionB_valid = 1; instructionB = 32'h70 + p; addressB = 32'h700 + p;
            step();
        end
        total++; if (entry_count !== 4'd4) begin bad++; $display("FAIL areset_pre got=%0d exp=4", entry_count); end
        #2 rst = 0;
        #1;
        total++; if (entry_count !== 4'd0 || stall !== 1'b0 || entry0_address !== 32'h0 || entry1_address !== 32'h0) begin bad++;
            $display("FAIL areset_now got=%0d/%0b/%h/%h exp=0/0/0/0", entry_count, stall, entry0_address, entry1_address); end
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        instructionA_valid = 1; instructionA = 32'h99; addressA = 32'h900;
        step();
        total++; if (entry_count !== 4'd1 || entry0_instruction !== 32'h99) begin bad++;
            $display("FAIL areset_after got=%0d/%h exp=1/99", entry_count, entry0_instruction); end
    endtask

    initial begin
        rst = 0;
        idle();
        test_reset();
        test_single_push();
        test_dual();
        test_fill_wrap();
        test_flush();
        test_pop_edges();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
